// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches between fetch and execute. Resolves the
// oldest entry, flushes on mispredict, and emits predictor training updates.
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enq_valid,
   input  logic [31:0]                enq_pc,
   input  logic                       enq_pred_taken,
   input  logic [31:0]                enq_pred_target,
   output logic                       enq_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [31:0]                res_target,
   output logic                       flush,
   output logic [31:0]                redirect_pc,
   output logic                       upd_valid,
   output logic [31:0]                upd_pc,
   output logic                       upd_actual,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           branch_count,
   output logic [CNT_W-1:0]           mispredict_count,
   output logic                       err_underflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state_reg, state_next;
   logic [PTR_W-1:0]   head_reg, tail_reg;
   logic [OCC_W-1:0]   occ_reg;
   logic [31:0]        pc_mem     [DEPTH];
   logic               taken_mem  [DEPTH];
   logic [31:0]        target_mem [DEPTH];

   logic [31:0]        redirect_pc_reg, upd_pc_reg;
   logic               upd_valid_reg, upd_actual_reg, err_underflow_reg;
   logic [CNT_W-1:0]   branch_count_reg, mispredict_count_reg;

   logic               full, empty;
   logic               enq_fire, res_fire, mispredict, underflow;
   logic [31:0]        head_pc, head_target, redirect_next;
   logic               head_taken;

   assign full        = (occ_reg == OCC_W'(DEPTH));
   assign empty       = (occ_reg == '0);
   assign head_pc     = pc_mem[head_reg];
   assign head_taken  = taken_mem[head_reg];
   assign head_target = target_mem[head_reg];
   assign redirect_next = res_taken ? res_target : head_pc + 32'd4;

   always_comb begin
      state_next = state_reg;
      enq_ready  = 1'b0;
      enq_fire   = 1'b0;
      res_fire   = 1'b0;
      mispredict = 1'b0;
      underflow  = 1'b0;
      case (state_reg)
         RUN: begin
            enq_ready  = !full;
            enq_fire   = enq_valid && !full;
            res_fire   = res_valid && !empty;
            underflow  = res_valid && empty;
            mispredict = res_fire && ((res_taken != head_taken) ||
                         (res_taken && head_taken && (res_target != head_target)));
            if (mispredict)
               state_next = FLUSH;
         end
         FLUSH: begin
            // Anything resolved here belongs to the discarded path.
            state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         head_reg  <= '0;
         tail_reg  <= '0;
         occ_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (mispredict) begin
            // Younger entries are wrong-path; a same-cycle enqueue is dropped too.
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
         end else begin
            if (enq_fire) tail_reg <= tail_reg + PTR_W'(1);
            if (res_fire) head_reg <= head_reg + PTR_W'(1);
            case ({enq_fire, res_fire})
               2'b10:   occ_reg <= occ_reg + OCC_W'(1);
               2'b01:   occ_reg <= occ_reg - OCC_W'(1);
               default: occ_reg <= occ_reg;
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (enq_fire && !mispredict && tail_reg == PTR_W'(gi)) begin
            pc_mem[gi]     <= enq_pc;
            taken_mem[gi]  <= enq_pred_taken;
            target_mem[gi] <= enq_pred_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_pc_reg      <= '0;
         upd_valid_reg        <= 1'b0;
         upd_pc_reg           <= '0;
         upd_actual_reg       <= 1'b0;
         branch_count_reg     <= '0;
         mispredict_count_reg <= '0;
         err_underflow_reg    <= 1'b0;
      end else begin
         upd_valid_reg <= res_fire;
         if (res_fire) begin
            upd_pc_reg     <= head_pc;
            upd_actual_reg <= res_taken;
            if (branch_count_reg != '1)
               branch_count_reg <= branch_count_reg + CNT_W'(1);
         end
         if (mispredict) begin
            redirect_pc_reg <= redirect_next;
            if (mispredict_count_reg != '1)
               mispredict_count_reg <= mispredict_count_reg + CNT_W'(1);
         end
         if (underflow)
            err_underflow_reg <= 1'b1;
      end
   end

   assign flush            = (state_reg == FLUSH);
   assign redirect_pc      = redirect_pc_reg;
   assign upd_valid        = upd_valid_reg;
   assign upd_pc           = upd_pc_reg;
   assign upd_actual       = upd_actual_reg;
   assign occupancy        = occ_reg;
   assign branch_count     = branch_count_reg;
   assign mispredict_count = mispredict_count_reg;
   assign err_underflow    = err_underflow_reg;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench: stimulus queues expected training/flush outputs, a monitor
// pops and compares them whenever the DUT presents one.
module tb_branch_resolve_queue;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enq_valid = 1'b0;
   logic [31:0]       enq_pc = '0;
   logic              enq_pred_taken = 1'b0;
   logic [31:0]       enq_pred_target = '0;
   logic              enq_ready;
   logic              res_valid = 1'b0;
   logic              res_taken = 1'b0;
   logic [31:0]       res_target = '0;
   logic              flush;
   logic [31:0]       redirect_pc;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic              upd_actual;
   logic [$clog2(DEPTH):0] occupancy;
   logic [CNT_W-1:0]  branch_count, mispredict_count;
   logic              err_underflow;

   typedef struct {
      logic [31:0] pc;
      logic        actual;
   } upd_t;

   upd_t        exp_upd[$];
   logic [31:0] exp_flush[$];
   int          total = 0;
   int          passed = 0;
   bit          mon_en = 1'b0;
   logic        prev_flush = 1'b0;

   branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
      .enq_pred_target(enq_pred_target), .enq_ready(enq_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_actual(upd_actual),
      .occupancy(occupancy), .branch_count(branch_count),
      .mispredict_count(mispredict_count), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      enq_valid = 1'b1; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tgt;
      tick();
      enq_valid = 1'b0;
   endtask

   // Drives one resolve; expected outputs are supplied by the caller.
   task automatic resolve(input logic t, input logic [31:0] tgt);
      res_valid = 1'b1; res_taken = t; res_target = tgt;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic push_upd(input logic [31:0] pc, input logic actual);
      upd_t u;
      u.pc = pc; u.actual = actual;
      exp_upd.push_back(u);
   endtask

   // Monitor: compares every presented output against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (upd_valid) begin
            if (exp_upd.size() == 0) begin
               chk("unexpected_upd", upd_pc, 32'hDEAD_BEEF);
            end else begin
               upd_t e;
               e = exp_upd.pop_front();
               $display("upd pc=%h actual=%0d (exp pc=%h actual=%0d)", upd_pc, upd_actual, e.pc, e.actual);
               chk("upd_pc", upd_pc, e.pc);
               chk("upd_actual", {31'd0, upd_actual}, {31'd0, e.actual});
            end
         end
         if (flush) begin
            chk("flush_width", {31'd0, prev_flush}, 32'd0);
            if (exp_flush.size() == 0) begin
               chk("unexpected_flush", redirect_pc, 32'hDEAD_BEEF);
            end else begin
               logic [31:0] r;
               r = exp_flush.pop_front();
               $display("flush redirect_pc=%h (exp %h)", redirect_pc, r);
               chk("redirect_pc", redirect_pc, r);
            end
         end
      end
      prev_flush = flush;
   end

   initial begin
      tick(); tick();
      rst = 1'b0;
      #1;
      mon_en = 1'b1;
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_ready", {31'd0, enq_ready}, 1);
      chk("rst_flush", {31'd0, flush}, 0);
      chk("rst_upd_valid", {31'd0, upd_valid}, 0);
      chk("rst_branch", 32'(branch_count), 0);
      chk("rst_mis", 32'(mispredict_count), 0);
      chk("rst_err", {31'd0, err_underflow}, 0);
      chk("rst_redirect", redirect_pc, 0);

      // Fill to capacity; further enqueues are refused, even alongside a pop.
      for (int i = 0; i < DEPTH; i++) enq(32'h10 + 32'(4 * i), 1'b0, 32'h0);
      chk("full_occ", 32'(occupancy), 4);
      chk("full_ready", {31'd0, enq_ready}, 0);
      enq(32'h99, 1'b0, 32'h0);
      chk("full_refuse_occ", 32'(occupancy), 4);
      enq_valid = 1'b1; enq_pc = 32'h99;
      push_upd(32'h10, 1'b0);
      resolve(1'b0, 32'h0);
      enq_valid = 1'b0;
      chk("pop_occ", 32'(occupancy), 3);
      chk("pop_ready", {31'd0, enq_ready}, 1);
      for (int i = 1; i < DEPTH; i++) begin
         push_upd(32'h10 + 32'(4 * i), 1'b0);
         resolve(1'b0, 32'h0);
      end
      chk("drain_occ", 32'(occupancy), 0);
      chk("drain_branch", 32'(branch_count), 4);

      // Correct not-taken resolve.
      enq(32'h100, 1'b0, 32'h0);
      push_upd(32'h100, 1'b0);
      resolve(1'b0, 32'h0);
      chk("nt_flush", {31'd0, flush}, 0);
      chk("nt_branch", 32'(branch_count), 5);
      chk("nt_mis", 32'(mispredict_count), 0);

      // Wrong target with younger entries queued behind.
      enq(32'h200, 1'b1, 32'h400);
      enq(32'h204, 1'b0, 32'h0);
      enq(32'h208, 1'b0, 32'h0);
      chk("tgt_occ_before", 32'(occupancy), 3);
      push_upd(32'h200, 1'b1);
      exp_flush.push_back(32'h480);
      resolve(1'b1, 32'h480);
      chk("tgt_flush", {31'd0, flush}, 1);
      chk("tgt_ready", {31'd0, enq_ready}, 0);
      chk("tgt_occ", 32'(occupancy), 0);
      chk("tgt_mis", 32'(mispredict_count), 1);
      chk("tgt_branch", 32'(branch_count), 6);
      // Resolve during FLUSH is wrong-path and must not count or underflow.
      resolve(1'b0, 32'h0);
      chk("post_flush", {31'd0, flush}, 0);
      chk("flush_res_err", {31'd0, err_underflow}, 0);
      chk("flush_res_branch", 32'(branch_count), 6);
      chk("post_flush_ready", {31'd0, enq_ready}, 1);

      // Not-taken redirect wraps to 0; same-cycle enqueue is dropped.
      enq(32'hFFFF_FFFC, 1'b1, 32'h50);
      push_upd(32'hFFFF_FFFC, 1'b0);
      exp_flush.push_back(32'h0);
      enq_valid = 1'b1; enq_pc = 32'h300;
      resolve(1'b0, 32'h0);
      enq_valid = 1'b0;
      chk("wrap_occ", 32'(occupancy), 0);
      chk("wrap_mis", 32'(mispredict_count), 2);
      tick();
      chk("wrap_occ_after", 32'(occupancy), 0);

      // Underflow is sticky and leaves counters alone.
      resolve(1'b1, 32'h0);
      chk("uf_err", {31'd0, err_underflow}, 1);
      chk("uf_branch", 32'(branch_count), 7);
      tick();
      chk("uf_err_hold", {31'd0, err_underflow}, 1);

      // Predicted not-taken, actually taken.
      enq(32'h500, 1'b0, 32'h0);
      push_upd(32'h500, 1'b1);
      exp_flush.push_back(32'h600);
      resolve(1'b1, 32'h600);
      chk("ntt_mis", 32'(mispredict_count), 3);
      tick();

      // Taken with matching target is correct.
      enq(32'h700, 1'b1, 32'h800);
      push_upd(32'h700, 1'b1);
      resolve(1'b1, 32'h800);
      chk("tt_flush", {31'd0, flush}, 0);
      chk("tt_branch", 32'(branch_count), 9);

      // Drive branch_count into saturation.
      for (int i = 0; i < 7; i++) begin
         enq(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
         push_upd(32'h1000 + 32'(4 * i), 1'b0);
         resolve(1'b0, 32'h0);
         chk("sat_branch", 32'(branch_count), (10 + i > SAT) ? SAT : 10 + i);
      end

      // Reset in the middle of a flush.
      enq(32'h900, 1'b0, 32'h0);
      push_upd(32'h900, 1'b1);
      exp_flush.push_back(32'hA00);
      resolve(1'b1, 32'hA00);
      chk("sat_hold", 32'(branch_count), SAT);
      chk("mid_flush", {31'd0, flush}, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_flush", {31'd0, flush}, 0);
      chk("rst2_occ", 32'(occupancy), 0);
      chk("rst2_branch", 32'(branch_count), 0);
      chk("rst2_mis", 32'(mispredict_count), 0);
      chk("rst2_err", {31'd0, err_underflow}, 0);
      tick(); tick();
      chk("upd_left", 32'(exp_upd.size()), 0);
      chk("flush_left", 32'(exp_flush.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between fetch and execute, alongside the 2-bit BHT predictor.
- Holds every in-flight predicted branch in program order.
- When execute resolves the oldest branch, compares prediction with outcome and raises a flush plus redirect PC on a mispredict.
- Emits the per-branch training update (valid, pc, actual) that drives the predictor's branch/pc/actual inputs; also keeps branch and mispredict statistics.

Parameters:
DEPTH, 4, number of in-flight branch entries; power of two, at least 2
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
enq_valid  in  1  fetch presents a predicted branch
enq_pc  in  32  branch instruction PC
enq_pred_taken  in  1  predicted direction
enq_pred_target  in  32  predicted target; don't-care when not taken
enq_ready  out  1  queue can accept this cycle
res_valid  in  1  execute resolves the oldest outstanding branch
res_taken  in  1  actual direction
res_target  in  32  actual target; valid when res_taken
flush  out  1  one-cycle mispredict flush pulse
redirect_pc  out  32  correct fetch PC, valid while flush=1
upd_valid  out  1  predictor training strobe
upd_pc  out  32  PC of the resolved branch
upd_actual  out  1  actual direction of the resolved branch
occupancy  out  $clog2(DEPTH)+1  entries currently held
branch_count  out  CNT_W  resolved branches, saturating
mispredict_count  out  CNT_W  mispredicted branches, saturating
err_underflow  out  1  sticky: resolve arrived with the queue empty

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-flush):
  - Pointers and occupancy go to 0; FSM goes to RUN.
  - flush, upd_valid, err_underflow and both counters go to 0; redirect_pc and upd_pc go to 0.
- Storage: circular buffer of DEPTH entries {pc, pred_taken, pred_target}.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full when occupancy == DEPTH; empty when occupancy == 0.
- FSM has two states, RUN and FLUSH.
- RUN:
  - enq_ready = !full, combinational from registered state only; no bypass, so a full queue refuses enq even when a pop happens in the same cycle.
  - Enqueue fires when enq_valid && enq_ready: write the entry at tail, tail+1.
  - Resolve fires when res_valid && !empty: head entry is compared and popped.
  - Mispredict when res_taken != pred_taken, or when both are 1 and res_target != pred_target.
  - Correct resolve: pop head, head+1. An enqueue in the same cycle is also accepted, so occupancy is unchanged.
  - Mispredict: all younger entries are wrong-path. On the same edge, clear the queue (head=tail=0, occupancy=0) and drop any same-cycle enqueue. Set flush=1. Set redirect_pc = res_target if res_taken, else head pc + 4 (32-bit wrap). Go to FLUSH.
  - res_valid with an empty queue: no pop, no counter change, no upd_valid; err_underflow sets and stays 1 until rst.
- FLUSH (exactly one cycle):
  - flush=1, enq_ready=0.
  - res_valid is ignored as wrong-path: no underflow, no counting.
  - Next state is RUN, and flush returns to 0.
- Training output (registered, 1-cycle latency after every resolve that pops, correct or mispredicted):
  - upd_valid=1, upd_pc = head pc, upd_actual = res_taken.
  - Otherwise upd_valid=0.
- Counters update on the same edge as the pop:
  - branch_count +1 on each pop; mispredict_count +1 on each mispredict.
  - Both saturate at all-ones and never wrap.
- redirect_pc holds its last value when flush=0.

Test Plan:
- Fill to DEPTH=4 with no resolves → enq_ready=0, occupancy=4. Assert enq_valid with res_valid=0 → nothing accepted. One correct resolve → occupancy=3, enq_ready=1 on the next cycle.
- Enqueue pc=0x100 pred NT, resolve res_taken=0 → no flush; next cycle upd_valid=1, upd_pc=0x100, upd_actual=0; branch_count=1, mispredict_count=0.
- Enqueue 0x200 pred T, target 0x400, plus two younger entries; resolve taken with target 0x480 → flush=1 for exactly one cycle, redirect_pc=0x480, occupancy=0, mispredict_count=1, enq_ready=0 during the flush cycle.
- Enqueue 0xFFFFFFFC pred T; resolve not taken → redirect_pc=0x00000000 (wrap). A same-cycle enq_valid is dropped; occupancy=0 after the edge.
- res_valid on an empty queue → err_underflow=1 and it holds; counters unchanged. res_valid during FLUSH does not set err_underflow.
- Force branch_count to all-ones via 65535 resolves (or a small-CNT_W build) → the further resolve stays at 0xFFFF. Assert rst mid-FLUSH → the next cycle shows flush=0, occupancy=0, all counters 0.
